pdp8_mem_responder: RTL
=======================

PDP8_MEM_RESPONDER -- requirements
Module: pdp8_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 12, meaning word width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports ifu_rd_req  input  1 and ifu_rd_addr  input  ADDR_WIDTH: the fetch-unit read request pulse and its address.
REQ-006 SHALL have ports ifu_rd_data  output  DATA_WIDTH and ifu_rd_valid  output  1: fetch read data and its one-cycle valid strobe.
REQ-007 SHALL have ports exec_rd_req  input  1, exec_rd_addr  input  ADDR_WIDTH, exec_rd_data  output  DATA_WIDTH and exec_rd_valid  output  1: the execute-unit read channel.
REQ-008 SHALL have ports exec_wr_req  input  1, exec_wr_addr  input  ADDR_WIDTH, exec_wr_data  input  DATA_WIDTH and exec_wr_ack  output  1: the execute-unit write channel.
REQ-009 SHALL have ports sram_en  output  1, sram_we  output  1, sram_addr  output  ADDR_WIDTH, sram_wdata  output  DATA_WIDTH and sram_rdata  input  DATA_WIDTH: a single-port SRAM with 1-cycle read latency.
REQ-010 SHALL have port mem_busy  output  1: high when any request is pending or in flight.
REQ-011 SHALL have port err_overrun  output  1: sticky flag for a request lost to overrun.

Function
REQ-012 SHALL treat each *_req as a one-cycle pulse and capture its address (and write data) into a per-source pending register on that edge.
REQ-013 SHALL hold at most one pending request per source: ifu_rd, exec_rd and exec_wr.
REQ-014 SHALL implement FSM states IDLE and RD_WAIT.
REQ-015 SHALL, in IDLE with any request pending, issue exactly one request in that cycle, with priority exec_wr > exec_rd > ifu_rd.
REQ-016 SHALL drive sram_* combinationally from state and pending registers; sram_en=0, sram_we=0, sram_addr=0 and sram_wdata=0 when no issue occurs.
REQ-017 SHALL, on a write issue (sram_en=1, sram_we=1), clear wr pending, stay in IDLE and pulse exec_wr_ack high for exactly the next cycle.
REQ-018 SHALL, on a read issue (sram_en=1, sram_we=0), clear that source's pending bit, record the source and go to RD_WAIT.
REQ-019 SHALL, in RD_WAIT, issue nothing, latch sram_rdata into the recorded source's *_rd_data, pulse that source's *_rd_valid for the next cycle only, and return to IDLE.
REQ-020 SHALL hold *_rd_data stable between responses.
REQ-021 SHALL give minimum latencies of: request at cycle N, read valid at N+3, write ack at N+2.
REQ-022 SHALL give sustained throughput of one read per 2 cycles or one write per cycle.
REQ-023 SHALL order a write and a read to the same address pending together write-first, so the read returns the new data.
REQ-024 SHALL, when a req pulse arrives while that source is still pending, ignore the new request, keep the old one, and set err_overrun (cleared only by reset).
REQ-025 SHALL allow a req pulse to be accepted in the same cycle its source's pending request is issued, with no overrun.
REQ-026 SHALL drive mem_busy = (any pending) OR (state == RD_WAIT).

Reset
REQ-027 SHALL, while reset is high, force state IDLE, clear all pending registers, and set ifu_rd_data=0, exec_rd_data=0, all valid/ack=0 and err_overrun=0.
REQ-028 SHALL, on reset asserted mid-operation (RD_WAIT or pending), discard in-flight and pending requests and produce no valid/ack after reset releases.
REQ-029 SHALL ignore *_req pulses during the reset cycle.

Verification
REQ-030 SHALL cover a single fetch: ifu_rd_req at cycle 0 with addr 0o200, SRAM holds 0o7200 -> sram_en at cycle 1, ifu_rd_valid=1 with ifu_rd_data=0o7200 at cycle 3 only.
REQ-031 SHALL cover a simultaneous three-way request at cycle 0 -> write issued cycle 1 (ack cycle 2), exec_rd issued cycle 2 (valid cycle 4), ifu_rd issued cycle 4 (valid cycle 6).
REQ-032 SHALL cover RAW ordering: exec_wr 0o1234 to 0o50 and exec_rd of 0o50 both at cycle 0 -> exec_rd_data=0o1234 at cycle 4.
REQ-033 SHALL cover overrun: ifu_rd_req at cycles 0 and 1 while exec_rd is pending -> only the first address is served and err_overrun=1 from cycle 2.
REQ-034 SHALL cover mid-read reset: reset in the RD_WAIT cycle -> no ifu_rd_valid, mem_busy=0 and all outputs 0 afterwards.

Source files
------------

// File: rtl/pdp8_mem_responder_if.sv
// Request/response bundle between the fetch/execute units, the responder and
// its single-port SRAM. Slave is the responder's view; master is the
// requesters plus the SRAM.
interface pdp8_mem_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
);
  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  logic                  ifu_rd_valid;

  logic                  exec_rd_req;
  logic [ADDR_WIDTH-1:0] exec_rd_addr;
  logic [DATA_WIDTH-1:0] exec_rd_data;
  logic                  exec_rd_valid;

  logic                  exec_wr_req;
  logic [ADDR_WIDTH-1:0] exec_wr_addr;
  logic [DATA_WIDTH-1:0] exec_wr_data;
  logic                  exec_wr_ack;

  logic                  sram_en;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;

  logic                  mem_busy;
  logic                  err_overrun;

  modport slave (
    input  ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_rd_addr,
           exec_wr_req, exec_wr_addr, exec_wr_data, sram_rdata,
    output ifu_rd_data, ifu_rd_valid, exec_rd_data, exec_rd_valid,
           exec_wr_ack, sram_en, sram_we, sram_addr, sram_wdata,
           mem_busy, err_overrun
  );

  modport master (
    output ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_rd_addr,
           exec_wr_req, exec_wr_addr, exec_wr_data, sram_rdata,
    input  ifu_rd_data, ifu_rd_valid, exec_rd_data, exec_rd_valid,
           exec_wr_ack, sram_en, sram_we, sram_addr, sram_wdata,
           mem_busy, err_overrun
  );
endinterface

// File: rtl/pdp8_mem_responder.sv
// Arbitrates fetch reads, execute reads and execute writes onto one
// single-port SRAM (1-cycle read latency). One pending slot per source;
// writes win over exec reads, which win over fetch reads, so a write and a
// read to the same address pending together return the new data.
module pdp8_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input logic                   clk,
  input logic                   reset,
  pdp8_mem_responder_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] addr;
  } rd_pend_t;

  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_pend_t;

  state_t   state, state_nxt;
  rd_pend_t ifu_q, erd_q;
  wr_pend_t ewr_q;
  logic     src_exec_q;      // source of the read in flight: 1 = exec, 0 = fetch
  logic     iss_wr, iss_erd, iss_ifu;
  logic     ifu_acc, erd_acc, ewr_acc, ovr;

  logic [DATA_WIDTH-1:0] ifu_data_q, erd_data_q;
  logic                  ifu_vld_q, erd_vld_q, ack_q, err_q;

  // A slot can take a new request if empty or being issued this cycle;
  // a request hitting an occupied, non-issuing slot is lost.
  assign ifu_acc = bus.ifu_rd_req  & (~ifu_q.vld | iss_ifu);
  assign erd_acc = bus.exec_rd_req & (~erd_q.vld | iss_erd);
  assign ewr_acc = bus.exec_wr_req & (~ewr_q.vld | iss_wr);
  assign ovr     = (bus.ifu_rd_req  & ifu_q.vld & ~iss_ifu) |
                   (bus.exec_rd_req & erd_q.vld & ~iss_erd) |
                   (bus.exec_wr_req & ewr_q.vld & ~iss_wr);

  // Fixed-priority issue in IDLE, SRAM drive and next state
  always_comb begin
    state_nxt      = state;
    iss_wr         = 1'b0;
    iss_erd        = 1'b0;
    iss_ifu        = 1'b0;
    bus.sram_en    = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    case (state)
      IDLE: begin
        if (ewr_q.vld) begin
          iss_wr         = 1'b1;
          bus.sram_en    = 1'b1;
          bus.sram_we    = 1'b1;
          bus.sram_addr  = ewr_q.addr;
          bus.sram_wdata = ewr_q.data;
        end else if (erd_q.vld) begin
          iss_erd       = 1'b1;
          bus.sram_en   = 1'b1;
          bus.sram_addr = erd_q.addr;
          state_nxt     = RD_WAIT;
        end else if (ifu_q.vld) begin
          iss_ifu       = 1'b1;
          bus.sram_en   = 1'b1;
          bus.sram_addr = ifu_q.addr;
          state_nxt     = RD_WAIT;
        end
      end
      RD_WAIT: state_nxt = IDLE;
    endcase
  end

  // State register and in-flight read source
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      src_exec_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (iss_erd)      src_exec_q <= 1'b1;
      else if (iss_ifu) src_exec_q <= 1'b0;
    end
  end

  // Per-source pending slots; accept wins over clear on the issue cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifu_q <= '0;
      erd_q <= '0;
      ewr_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (ifu_acc)      ifu_q <= '{vld: 1'b1, addr: bus.ifu_rd_addr};
      else if (iss_ifu) ifu_q.vld <= 1'b0;
      if (erd_acc)      erd_q <= '{vld: 1'b1, addr: bus.exec_rd_addr};
      else if (iss_erd) erd_q.vld <= 1'b0;
      if (ewr_acc)      ewr_q <= '{vld: 1'b1, addr: bus.exec_wr_addr, data: bus.exec_wr_data};
      else if (iss_wr)  ewr_q.vld <= 1'b0;
      err_q <= err_q | ovr;
    end
  end

  // Responses: one-cycle strobes, read data held until the next response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifu_data_q <= '0;
      erd_data_q <= '0;
      ifu_vld_q  <= 1'b0;
      erd_vld_q  <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ack_q     <= iss_wr;
      ifu_vld_q <= 1'b0;
      erd_vld_q <= 1'b0;
      if (state == RD_WAIT) begin
        if (src_exec_q) begin
          erd_data_q <= bus.sram_rdata;
          erd_vld_q  <= 1'b1;
        end else begin
          ifu_data_q <= bus.sram_rdata;
          ifu_vld_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.ifu_rd_data   = ifu_data_q;
  assign bus.ifu_rd_valid  = ifu_vld_q;
  assign bus.exec_rd_data  = erd_data_q;
  assign bus.exec_rd_valid = erd_vld_q;
  assign bus.exec_wr_ack   = ack_q;
  assign bus.err_overrun   = err_q;
  assign bus.mem_busy      = ifu_q.vld | erd_q.vld | ewr_q.vld | (state == RD_WAIT);

endmodule
